// File: rtl/dds_pkg.sv
// Shared definitions for the DDS control port: command frame geometry,
// address field layout and the SPI receiver state encoding.
package dds_pkg;

  localparam int CMD_PW = 24;
  localparam int CMD_AW = 8;
  localparam int CMD_DW = 16;

  // Address byte: upper nibble selects the voice, lower nibble is a one-hot register select
  localparam int VOICE_MSB = 7;
  localparam int VOICE_LSB = 4;

  localparam logic [3:0] REG_FREQ   = 4'b0001;
  localparam logic [3:0] REG_MOD    = 4'b0010;
  localparam logic [3:0] REG_WAVE   = 4'b0100;
  localparam logic [3:0] REG_ENABLE = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } rx_state_t;

  function automatic logic [3:0] voice_of(input logic [CMD_AW-1:0] addr);
    return addr[VOICE_MSB:VOICE_LSB];
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a history flop
// producing single-cycle rise/fall strobes in the clk domain.
module sync_edge #(
  parameter int SYNC    = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC-1:0] chain_p0;
  logic            hist_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_p0 <= {SYNC{RST_VAL}};
      hist_p1  <= RST_VAL;
    end else begin
      chain_p0 <= {chain_p0[SYNC-2:0], d};
      hist_p1  <= chain_p0[SYNC-1];
    end
  end

  assign s    = chain_p0[SYNC-1];
  assign rise = s & ~hist_p1;
  assign fall = hist_p1 & ~s;

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI responder that deframes 24-bit {addr, data} commands (MSB first) and
// offers them to the voice register file through a valid/ready holding register.
module spi_cmd_rx
  import dds_pkg::*;
#(
  parameter int PW   = CMD_PW,
  parameter int AW   = CMD_AW,
  parameter int DW   = CMD_DW,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          mosi,
  input  logic          csb,
  output logic [AW-1:0] cmd_addr,
  output logic [DW-1:0] cmd_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          frame_err,
  output logic          overrun,
  input  logic          clr_overrun
);

  localparam int CW = $clog2(PW + 1);
  localparam int WW = $clog2(SYNC + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic csb_s, csb_rise, csb_fall;
  logic unused_edges;

  sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .s(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .s(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  sync_edge #(.SYNC(SYNC), .RST_VAL(1'b1)) u_sync_csb (
    .clk(clk), .rst_n(rst_n), .d(csb), .s(csb_s), .rise(csb_rise), .fall(csb_fall)
  );

  assign unused_edges = ^{sclk_s, sclk_rise, mosi_rise, mosi_fall};

  rx_state_t       state, state_nx;
  logic [PW-1:0]   sr, sr_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            frame_err_nx;
  logic            load, drop, accept;
  logic [WW-1:0]   warm;
  logic            armed;

  assign accept = cmd_valid & cmd_ready;

  // The csb chain resets high, so a pin held low through reset would look like a
  // fresh csb fall once the chain fills; only trust csb_s after it has been
  // seen high with real pin data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      if (warm != WW'(SYNC)) warm <= warm + WW'(1);
      armed <= armed | ((warm == WW'(SYNC)) & csb_s);
    end
  end

  always_comb begin
    state_nx     = state;
    sr_nx        = sr;
    cnt_nx       = cnt;
    frame_err_nx = 1'b0;
    load         = 1'b0;
    drop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (csb_fall && armed) begin
          cnt_nx   = '0;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A fall coinciding with csb_rise is still shifted before the length check
        if (sclk_fall) begin
          sr_nx = {sr[PW-2:0], mosi_s};
          if (cnt != CW'(PW)) cnt_nx = cnt + CW'(1);
        end
        if (csb_rise) begin
          if (cnt_nx == CW'(PW)) begin
            state_nx = ST_COMMIT;
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        if (!cmd_valid || accept) load = 1'b1;
        else                      drop = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sr        <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      cnt       <= cnt_nx;
      frame_err <= frame_err_nx;
    end
  end

  // Holding register: a commit in the accept cycle keeps cmd_valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_addr  <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        cmd_addr  <= sr[PW-1:DW];
        cmd_data  <= sr[DW-1:0];
        cmd_valid <= 1'b1;
      end else if (accept) begin
        cmd_valid <= 1'b0;
      end
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule
